// File: rtl/multi_light_shader_pkg.sv
// Shared types and constants for the multi-light shading stage: the RGB565
// pixel layout, light addressing, the fixed-point intensity format and the
// controller state encoding.
package multi_light_shader_pkg;

  localparam int DEFAULT_MAX_LIGHTS = 4;
  localparam int LIGHT_FRAC_BITS    = 14;
  localparam logic [15:0] DEFAULT_AMBIENT = 16'd4096;  // 0.25 in 2.14

  localparam logic [4:0] RB_MAX = 5'd31;
  localparam logic [5:0] G_MAX  = 6'd63;

  // Width of a light index; a single-light configuration still gets one bit.
  function automatic int light_addr_w(input int max_lights);
    return (max_lights > 1) ? $clog2(max_lights) : 1;
  endfunction

  localparam int LIGHT_ADDR_W = light_addr_w(DEFAULT_MAX_LIGHTS);
  typedef logic [LIGHT_ADDR_W-1:0] light_addr_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACCUM,
    S_DONE
  } shade_state_e;

  // Per-channel add that clamps at the channel maximum instead of wrapping.
  function automatic rgb565_t rgb565_sat_add(input rgb565_t a, input rgb565_t b);
    rgb565_t    s;
    logic [5:0] r_sum;
    logic [6:0] g_sum;
    logic [5:0] b_sum;
    r_sum = {1'b0, a.r} + {1'b0, b.r};
    g_sum = {1'b0, a.g} + {1'b0, b.g};
    b_sum = {1'b0, a.b} + {1'b0, b.b};
    s.r = r_sum[5] ? RB_MAX : r_sum[4:0];
    s.g = g_sum[6] ? G_MAX  : g_sum[5:0];
    s.b = b_sum[5] ? RB_MAX : b_sum[4:0];
    return s;
  endfunction

endpackage

// File: rtl/multi_light_shader_if.sv
// Signal bundle of the shader: pixel intake, per-light request/response
// channel and shaded pixel output. "master" is the shader block itself,
// "slave" is the surrounding environment that feeds and drains it.
interface multi_light_shader_if
  import multi_light_shader_pkg::*;
#(
  parameter int MAX_LIGHTS = DEFAULT_MAX_LIGHTS,
  parameter int INT_W      = 16
) ();

  localparam int ADDR_W = light_addr_w(MAX_LIGHTS);
  localparam int NUM_W  = $clog2(MAX_LIGHTS + 1);

  logic              valid_in;
  logic              ready_in;
  logic [15:0]       pixel_in;
  logic [NUM_W-1:0]  num_lights;

  logic              light_req_valid;
  logic              light_req_ready;
  logic [ADDR_W-1:0] light_req_addr;

  logic              light_rsp_valid;
  logic              light_rsp_shadowed;
  logic              light_rsp_sign;
  logic [INT_W-1:0]  light_rsp_intensity;

  logic              valid_out;
  logic              ready_out;
  logic [15:0]       pixel_out;

  logic              protocol_error;

  modport master (
    input  valid_in, pixel_in, num_lights,
    output ready_in,
    output light_req_valid, light_req_addr,
    input  light_req_ready,
    input  light_rsp_valid, light_rsp_shadowed, light_rsp_sign, light_rsp_intensity,
    output valid_out, pixel_out,
    input  ready_out,
    output protocol_error
  );

  modport slave (
    output valid_in, pixel_in, num_lights,
    input  ready_in,
    input  light_req_valid, light_req_addr,
    output light_req_ready,
    output light_rsp_valid, light_rsp_shadowed, light_rsp_sign, light_rsp_intensity,
    input  valid_out, pixel_out,
    output ready_out,
    input  protocol_error
  );

endinterface

// File: rtl/multi_light_shader_rgb565_scale.sv
// Combinational RGB565 scaler: each channel is multiplied by an unsigned
// fixed-point factor, shifted down by FRAC_BITS and clamped to the channel
// maximum, so factors above 1.0 saturate rather than wrap.
module rgb565_scale
  import multi_light_shader_pkg::*;
#(
  parameter int INT_W     = 16,
  parameter int FRAC_BITS = LIGHT_FRAC_BITS
) (
  input  rgb565_t          colour,
  input  logic [INT_W-1:0] factor,
  output rgb565_t          scaled
);

  localparam int RB_W = INT_W + 5;
  localparam int G_W  = INT_W + 6;

  logic [RB_W-1:0] prod_r, prod_b, sh_r, sh_b;
  logic [G_W-1:0]  prod_g, sh_g;

  // Full-width products, shift to integer, then clamp per channel.
  always_comb begin
    // NOTE: default every output first so no path through the block leaves it unassigned (no latch).
    scaled = '0;
    prod_r = RB_W'(colour.r) * RB_W'(factor);
    prod_g = G_W'(colour.g)  * G_W'(factor);
    prod_b = RB_W'(colour.b) * RB_W'(factor);
    sh_r   = prod_r >> FRAC_BITS;
    sh_g   = prod_g >> FRAC_BITS;
    sh_b   = prod_b >> FRAC_BITS;
    scaled.r = (sh_r > RB_W'(RB_MAX)) ? RB_MAX : sh_r[4:0];
    scaled.g = (sh_g > G_W'(G_MAX))   ? G_MAX  : sh_g[5:0];
    scaled.b = (sh_b > RB_W'(RB_MAX)) ? RB_MAX : sh_b[4:0];
  end

endmodule

// File: rtl/multi_light_shader.sv
// Per-pixel multi-light shading accumulator. Accepts a base colour, seeds the
// accumulator with the ambient term, then walks num_lights lights: request,
// wait for shadow/sign/intensity, scale the base colour and saturating-add it.
// The result leaves through a valid/ready output that holds under backpressure.
module multi_light_shader
  import multi_light_shader_pkg::*;
#(
  parameter int               MAX_LIGHTS = DEFAULT_MAX_LIGHTS,
  parameter int               INT_W      = 16,
  parameter int               FRAC_BITS  = LIGHT_FRAC_BITS,
  parameter logic [INT_W-1:0] AMBIENT    = INT_W'(DEFAULT_AMBIENT)
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_light_shader_if.master bus
);

  localparam int ADDR_W = light_addr_w(MAX_LIGHTS);
  localparam int NUM_W  = $clog2(MAX_LIGHTS + 1);
  localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(MAX_LIGHTS);

  shade_state_e      state;
  rgb565_t           base;
  rgb565_t           acc;
  rgb565_t           contrib;
  logic [NUM_W-1:0]  num_lat;
  logic [ADDR_W-1:0] index;

  logic              ready_in_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              valid_out_q;
  logic [15:0]       pixel_out_q;
  logic              proto_err_q;

  rgb565_t           ambient_term;
  rgb565_t           light_term;
  logic [NUM_W-1:0]  num_clamped;
  logic              last_light;

  // Ambient term is computed straight from the incoming pixel so it can be
  // loaded into the accumulator on the accept edge.
  rgb565_scale #(.INT_W(INT_W), .FRAC_BITS(FRAC_BITS)) u_ambient_scale (
    .colour (rgb565_t'(bus.pixel_in)),
    .factor (AMBIENT),
    .scaled (ambient_term)
  );

  // Per-light contribution from the latched base colour and the live response.
  rgb565_scale #(.INT_W(INT_W), .FRAC_BITS(FRAC_BITS)) u_light_scale (
    .colour (base),
    .factor (bus.light_rsp_intensity),
    .scaled (light_term)
  );

  assign num_clamped = (bus.num_lights > MAX_NUM) ? MAX_NUM : bus.num_lights;
  assign last_light  = (NUM_W'(index) == (num_lat - NUM_W'(1)));

  // Controller: sequences intake, per-light requests, accumulation and output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      base        <= '0;
      acc         <= '0;
      contrib     <= '0;
      num_lat     <= '0;
      index       <= '0;
      ready_in_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      valid_out_q <= 1'b0;
      pixel_out_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      // A response is only legitimate while a request is outstanding.
      if (bus.light_rsp_valid && state != S_WAIT) proto_err_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.valid_in) begin
            base       <= rgb565_t'(bus.pixel_in);
            num_lat    <= num_clamped;
            acc        <= ambient_term;
            index      <= '0;
            req_addr_q <= '0;
            ready_in_q <= 1'b0;
            if (num_clamped == '0) begin
              state <= S_DONE;
            end else begin
              req_valid_q <= 1'b1;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus.light_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.light_rsp_valid) begin
            // Occluded or back-facing lights add nothing.
            contrib <= (bus.light_rsp_shadowed || bus.light_rsp_sign) ? '0 : light_term;
            state   <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          acc <= rgb565_sat_add(acc, contrib);
          if (last_light) begin
            state <= S_DONE;
          end else begin
            index       <= index + ADDR_W'(1);
            req_addr_q  <= index + ADDR_W'(1);
            req_valid_q <= 1'b1;
            state       <= S_REQ;
          end
        end

        S_DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!valid_out_q) begin
            valid_out_q <= 1'b1;
            pixel_out_q <= acc;
          end else if (bus.ready_out) begin
            valid_out_q <= 1'b0;
            ready_in_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_in        = ready_in_q;
  assign bus.light_req_valid = req_valid_q;
  assign bus.light_req_addr  = req_addr_q;
  assign bus.valid_out       = valid_out_q;
  assign bus.pixel_out       = pixel_out_q;
  assign bus.protocol_error  = proto_err_q;

endmodule
